// File: rtl/multi_cycle_control.sv
// Control FSM for a multi-cycle MIPS datapath: walks each instruction through
// fetch/decode/execute/memory/writeback and drives every select and enable.
module multi_cycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       FuncCode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             SignExtend,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_ERROR  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_FUNC = 4'b1111;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;
  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMM4  = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;

  function automatic state_t decode_target(input logic [5:0] op);
    state_t target;
    case (op)
      OP_LW, OP_SW:                 target = S_MEMADR;
      OP_RTYPE:                     target = S_EXEC;
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI:                       target = S_IEXEC;
      OP_BEQ, OP_BNE:               target = S_BRANCH;
      OP_J:                         target = S_JUMP;
      default:                      target = S_ERROR;
    endcase
    return target;
  endfunction

  // Shifts by immediate take their A operand from the shamt field.
  function automatic logic is_shamt_func(input logic [5:0] fn);
    return (fn == 6'b000000) || (fn == 6'b000010) || (fn == 6'b000011);
  endfunction

  // Every edge that returns to FETCH from a final state retires one instruction.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH:  if (MemReady) state_reg <= S_DECODE;
        S_DECODE: state_reg <= decode_target(Opcode);
        S_MEMADR: state_reg <= (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (MemReady) state_reg <= S_MEMWB;
        S_MEMWR: begin
          if (MemReady) begin
            state_reg <= S_FETCH;
            count_reg <= count_reg + CNT_W'(1);
          end
        end
        S_EXEC:   state_reg <= S_RWB;
        S_IEXEC:  state_reg <= S_IWB;
        S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
          state_reg <= S_FETCH;
          count_reg <= count_reg + CNT_W'(1);
        end
        S_ERROR:  state_reg <= S_ERROR;
        default:  state_reg <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    PCEn       = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemToReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    SignExtend = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    ALUOp      = ALU_ADD;
    PCSource   = PCSRC_ALU;
    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCEn    = MemReady;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMM4;
        SignExtend = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        SignExtend = 1'b1;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = is_shamt_func(FuncCode) ? SRCA_SHAMT : SRCA_A;
        ALUOp   = ALU_FUNC;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          OP_SLTI: begin ALUOp = ALU_SLT; SignExtend = 1'b1; end
          OP_ANDI: ALUOp = ALU_AND;
          OP_ORI:  ALUOp = ALU_OR;
          OP_XORI: ALUOp = ALU_XOR;
          OP_LUI:  ALUOp = ALU_LUI;
          default: begin ALUOp = ALU_ADD; SignExtend = 1'b1; end
        endcase
      end
      S_IWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = SRCA_A;
        ALUOp    = ALU_SUB;
        PCSource = PCSRC_ALUOUT;
        PCEn     = (Opcode == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCEn     = 1'b1;
      end
      default: ;
    endcase
    // Keep every write/strobe quiet while reset is held, whatever the state.
    if (Reset) begin
      PCEn     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign State      = state_reg;
  assign Illegal    = (state_reg == S_ERROR);
  assign InstrCount = count_reg;

endmodule
